// File: rtl/weight_rotator.sv
// Rotating weight-line driver: one active set, one shadow set, and a rotation index.
// Optional WROT_ZERO_IDLE_EN zeroes the lines whenever no active set is valid.
module weight_rotator #(
    parameter int unsigned ROWS  = 3,
    parameter int unsigned ROW_W = 48,
    parameter int unsigned IDX_W = $clog2(ROWS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ROWS*ROW_W-1:0]  w_data,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic                   row_adv,
    input  logic                   w_swap,
    output logic [ROWS*ROW_W-1:0]  lines,
    output logic                   out_valid,
    output logic [IDX_W-1:0]       rot_idx
);

    localparam int unsigned DW = ROWS * ROW_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } state_t;

    state_t           r_state;
    logic [DW-1:0]    r_active;
    logic [DW-1:0]    r_shadow;
    logic [IDX_W-1:0] r_rot;
    logic [DW-1:0]    r_lines;
    logic             r_out_valid;

    state_t           w_nxt_state;
    logic [DW-1:0]    w_nxt_active;
    logic [DW-1:0]    w_nxt_shadow;
    logic [IDX_W-1:0] w_nxt_rot;
    logic [IDX_W-1:0] w_rot_inc;
    logic             w_nxt_valid;
    logic             w_load;

    // Line i carries slice (i - r) mod ROWS; compare-and-subtract keeps the wrap exact.
    function automatic logic [DW-1:0] rotate(input logic [DW-1:0] d, input logic [IDX_W-1:0] r);
        logic [DW-1:0] o;
        int unsigned   ru;
        int unsigned   src;
        o  = '0;
        ru = 32'(r);
        for (int unsigned i = 0; i < ROWS; i++) begin
            src = (i >= ru) ? (i - ru) : (i + ROWS - ru);
            o[i*ROW_W +: ROW_W] = d[src*ROW_W +: ROW_W];
        end
        return o;
    endfunction

    assign w_ready   = (r_state != FULL);
    assign w_load    = w_valid && w_ready;
    assign w_rot_inc = (r_rot == IDX_W'(ROWS - 1)) ? '0 : r_rot + IDX_W'(1);

    // Next-state selection; a swap always resets the index and drops a concurrent advance.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_active = r_active;
        w_nxt_shadow = r_shadow;
        w_nxt_rot    = r_rot;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_nxt_active = w_data;
                    w_nxt_rot    = '0;
                    w_nxt_state  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_swap) begin
                    w_nxt_rot = '0;
                    if (w_load) begin
                        w_nxt_active = w_data;
                    end else begin
                        w_nxt_active = '0;
                        w_nxt_state  = IDLE;
                    end
                end else begin
                    if (w_load) begin
                        w_nxt_shadow = w_data;
                        w_nxt_state  = FULL;
                    end
                    if (row_adv) begin
                        w_nxt_rot = w_rot_inc;
                    end
                end
            end
            FULL: begin
                if (w_swap) begin
                    w_nxt_active = r_shadow;
                    w_nxt_shadow = '0;
                    w_nxt_rot    = '0;
                    w_nxt_state  = ACTIVE;
                end else if (row_adv) begin
                    w_nxt_rot = w_rot_inc;
                end
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
        w_nxt_valid = (w_nxt_state != IDLE);
    end

    // Lines are built from the next active set so they align with out_valid and rot_idx.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_active    <= '0;
            r_shadow    <= '0;
            r_rot       <= '0;
            r_lines     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_active    <= w_nxt_active;
            r_shadow    <= w_nxt_shadow;
            r_rot       <= w_nxt_rot;
            r_out_valid <= w_nxt_valid;
            if (w_nxt_valid) begin
                r_lines <= rotate(w_nxt_active, w_nxt_rot);
            end else begin
`ifdef WROT_ZERO_IDLE_EN
                r_lines <= '0;
`else
                r_lines <= r_lines;
`endif
            end
        end
    end

    assign lines     = r_lines;
    assign out_valid = r_out_valid;
    assign rot_idx   = r_rot;

endmodule

// File: tb/tb_weight_rotator.sv
// Directed, table-driven bench for weight_rotator (ROWS=3 main table, ROWS=5 wrap sequence).
module tb_weight_rotator;

    localparam logic [47:0] SA = 48'hAAAA_AAAA_AAAA;
    localparam logic [47:0] SB = 48'hBBBB_BBBB_BBBB;
    localparam logic [47:0] SC = 48'hCCCC_CCCC_CCCC;
    localparam logic [47:0] Y0 = 48'h1111_1111_1111;
    localparam logic [47:0] Y1 = 48'h2222_2222_2222;
    localparam logic [47:0] Y2 = 48'h3333_3333_3333;
    localparam logic [47:0] Z0 = 48'h4444_4444_4444;
    localparam logic [47:0] Z1 = 48'h5555_5555_5555;
    localparam logic [47:0] Z2 = 48'h6666_6666_6666;

    localparam logic [143:0] D_ABC = {SC, SB, SA};
    localparam logic [143:0] D_Y   = {Y2, Y1, Y0};
    localparam logic [143:0] D_Z   = {Z2, Z1, Z0};
    localparam logic [143:0] L_R1  = {SB, SA, SC};
    localparam logic [143:0] L_R2  = {SA, SC, SB};
    localparam logic [143:0] LZ_R1 = {Z1, Z0, Z2};
`ifdef WROT_ZERO_IDLE_EN
    localparam logic [143:0] L_IDLE = '0;
`else
    localparam logic [143:0] L_IDLE = LZ_R1;
`endif

    logic         clk = 1'b0;
    logic         rst, w_valid, row_adv, w_swap, w_ready, out_valid;
    logic [143:0] w_data, lines;
    logic [1:0]   rot_idx;

    logic         rst5, w_valid5, row_adv5, w_swap5, w_ready5, out_valid5;
    logic [39:0]  w_data5, lines5;
    logic [2:0]   rot_idx5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    weight_rotator #(.ROWS(3), .ROW_W(48)) dut (
        .clk(clk), .rst(rst), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .row_adv(row_adv), .w_swap(w_swap), .lines(lines), .out_valid(out_valid),
        .rot_idx(rot_idx)
    );

    weight_rotator #(.ROWS(5), .ROW_W(8)) dut5 (
        .clk(clk), .rst(rst5), .w_data(w_data5), .w_valid(w_valid5), .w_ready(w_ready5),
        .row_adv(row_adv5), .w_swap(w_swap5), .lines(lines5), .out_valid(out_valid5),
        .rot_idx(rot_idx5)
    );

    typedef struct {
        logic         rst;
        logic         vld;
        logic         adv;
        logic         swp;
        logic [143:0] data;
        logic [143:0] e_lines;
        logic [1:0]   e_rot;
        logic         e_ov;
        logic         e_rdy;
    } vec_t;

    vec_t tv[24];

    task automatic check(input string name, input int idx, input logic [143:0] got,
                         input logic [143:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
        end
    endtask

    initial begin
        //          rst   vld   adv   swp   data   lines   rot  ov    rdy
        tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, '0,    '0,     2'd0, 1'b0, 1'b1};
        tv[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, D_ABC, D_ABC,  2'd0, 1'b1, 1'b1};
        tv[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, '0,    L_R1,   2'd1, 1'b1, 1'b1};
        tv[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, '0,    L_R2,   2'd2, 1'b1, 1'b1};
        tv[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, '0,    D_ABC,  2'd0, 1'b1, 1'b1};
        tv[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, '0,    L_R1,   2'd1, 1'b1, 1'b1};
        tv[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, D_Y,   L_R1,   2'd1, 1'b1, 1'b0};
        tv[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, D_Z,   L_R2,   2'd2, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, '0,    D_Y,    2'd0, 1'b1, 1'b1};
        tv[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, D_Z,   D_Z,    2'd0, 1'b1, 1'b1};
        tv[10] = '{1'b0, 1'b0, 1'b1, 1'b0, '0,    LZ_R1,  2'd1, 1'b1, 1'b1};
        tv[11] = '{1'b0, 1'b0, 1'b1, 1'b1, '0,    L_IDLE, 2'd0, 1'b0, 1'b1};
        tv[12] = '{1'b0, 1'b0, 1'b1, 1'b0, '0,    L_IDLE, 2'd0, 1'b0, 1'b1};
        tv[13] = '{1'b0, 1'b0, 1'b0, 1'b1, '0,    L_IDLE, 2'd0, 1'b0, 1'b1};
        tv[14] = '{1'b0, 1'b1, 1'b0, 1'b0, D_ABC, D_ABC,  2'd0, 1'b1, 1'b1};
        tv[15] = '{1'b0, 1'b1, 1'b0, 1'b0, D_Y,   D_ABC,  2'd0, 1'b1, 1'b0};
        tv[16] = '{1'b0, 1'b0, 1'b1, 1'b0, '0,    L_R1,   2'd1, 1'b1, 1'b0};
        tv[17] = '{1'b0, 1'b0, 1'b1, 1'b0, '0,    L_R2,   2'd2, 1'b1, 1'b0};
        tv[18] = '{1'b1, 1'b0, 1'b0, 1'b1, '0,    '0,     2'd0, 1'b0, 1'b1};
        tv[19] = '{1'b0, 1'b1, 1'b1, 1'b0, D_ABC, D_ABC,  2'd0, 1'b1, 1'b1};
        tv[20] = '{1'b0, 1'b1, 1'b1, 1'b0, D_Y,   L_R1,   2'd1, 1'b1, 1'b0};
        tv[21] = '{1'b0, 1'b0, 1'b0, 1'b1, '0,    D_Y,    2'd0, 1'b1, 1'b1};
        tv[22] = '{1'b0, 1'b1, 1'b0, 1'b1, D_Z,   D_Z,    2'd0, 1'b1, 1'b1};
        tv[23] = '{1'b0, 1'b1, 1'b0, 1'b1, D_ABC, D_ABC,  2'd0, 1'b1, 1'b1};

        rst5 = 1'b1; w_valid5 = 1'b0; row_adv5 = 1'b0; w_swap5 = 1'b0; w_data5 = '0;

        for (int i = 0; i < 24; i++) begin
            rst     = tv[i].rst;
            w_valid = tv[i].vld;
            row_adv = tv[i].adv;
            w_swap  = tv[i].swp;
            w_data  = tv[i].data;
            @(posedge clk);
            #1;
            check("lines",     i, lines,                tv[i].e_lines);
            check("rot_idx",   i, 144'(rot_idx),        144'(tv[i].e_rot));
            check("out_valid", i, 144'(out_valid),      144'(tv[i].e_ov));
            check("w_ready",   i, 144'(w_ready),        144'(tv[i].e_rdy));
        end
        rst = 1'b0; w_valid = 1'b0; row_adv = 1'b0; w_swap = 1'b0; w_data = '0;

        // ROWS=5: load slices 0x10..0x14 then 7 advances across the non-power-of-2 wrap
        rst5 = 1'b0;
        w_valid5 = 1'b1;
        w_data5  = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
        @(posedge clk);
        #1;
        w_valid5 = 1'b0;
        check("r5_load_lines", 0, 144'(lines5), 144'(w_data5));
        check("r5_load_ov",    0, 144'(out_valid5), 144'(1'b1));
        for (int k = 1; k <= 7; k++) begin
            int unsigned exp_r;
            exp_r = k % 5;
            row_adv5 = 1'b1;
            @(posedge clk);
            #1;
            check("r5_rot",   k, 144'(rot_idx5), 144'(exp_r));
            check("r5_line0", k, 144'(lines5[7:0]), 144'(8'h10 + 8'((5 - exp_r) % 5)));
        end
        row_adv5 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/weight_rotator.md
# weight_rotator

Parametrised weight-line rotator for the PE array, generalising the fixed 3-row, 48-bit combinational line steering to ROWS lines of ROW_W bits. It holds one active weight set, a one-deep shadow set, and a rotation index, and drives registered, rotated weight lines to the PE rows. The rotation index advances as the convolution window slides down one input row, so each held kernel row reaches the correct PE line without reloading weights. The shadow buffer lets the next output channel's weights load while the current set is still in use.

## Interface
- ROWS, 3: number of weight lines / kernel rows; must be >= 2.
- ROW_W, 48: bits per weight line.
- IDX_W, $clog2(ROWS): derived width of the rotation index; do not override.

- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- w_data  in  ROWS*ROW_W  weight set; slice j = w_data[j*ROW_W +: ROW_W].
- w_valid  in  1  w_data valid.
- w_ready  out  1  a weight set can be accepted this cycle.
- row_adv  in  1  pulse; advance the rotation index by 1.
- w_swap  in  1  pulse; retire the active set and promote the shadow set.
- lines  out  ROWS*ROW_W  line i = lines[i*ROW_W +: ROW_W], registered.
- out_valid  out  1  lines carry a valid active set.
- rot_idx  out  IDX_W  current rotation index r, registered.

## Operation
- Mapping: line (j + r) mod ROWS carries active slice j. Equivalently, line i = slice (i − r + ROWS) mod ROWS. r=0 is the identity mapping.
- States:
  - IDLE: no active set.
  - ACTIVE: active set valid, shadow empty.
  - FULL: active and shadow both valid.
- w_ready = 1 in IDLE and ACTIVE, 0 in FULL. A load occurs on w_valid && w_ready.
- IDLE + load: data goes to active, r←0, move to ACTIVE.
- ACTIVE + load (no swap): data goes to shadow, move to FULL.
- ACTIVE + w_swap, no load: active is discarded, move to IDLE.
- ACTIVE + w_swap + load in the same cycle: the incoming data bypasses the shadow straight into active, r←0, stay in ACTIVE.
- FULL + w_swap: shadow→active, r←0, move to ACTIVE. Since w_ready=0 in FULL, no load can coincide.
- row_adv in ACTIVE/FULL: r ← (r==ROWS−1) ? 0 : r+1. Wrap is exact for non-power-of-2 ROWS.
- row_adv in IDLE is ignored.
- row_adv together with w_swap: the swap wins and r←0; the advance is dropped.
- w_swap in IDLE is ignored.
- A load never alters r except when it becomes the active set.
- out_valid = 1 in ACTIVE and FULL.
- No arithmetic on data; slices are moved bit-exact.

## Timing
- All outputs are registered. lines, rot_idx and out_valid reflect an event one cycle after the accepting edge (latency 1).
- w_ready is combinational from state only, never from w_valid.
- Reset: state IDLE, r=0, active and shadow cleared to 0, lines=0, rot_idx=0, out_valid=0. w_ready=1 from the first cycle after reset.
- Reset mid-operation discards both sets and any pending row_adv/w_swap in that cycle.
- Throughput: one row_adv per cycle sustained. Back-to-back swap+load every cycle keeps out_valid high continuously.

## Configuration
- WROT_ZERO_IDLE_EN defined: when out_valid=0, lines are forced to 0, including the cycle after a swap into IDLE.
- WROT_ZERO_IDLE_EN undefined: lines hold the last driven value when out_valid drops. Only out_valid qualifies the data.
- Behaviour of r, state and the handshake is identical either way.

## Test plan
- ROWS=3, ROW_W=48: load slices {S0,S1,S2}={0xA..,0xB..,0xC..}, then 3× row_adv.
  - Lines (l0,l1,l2) sequence: (A,B,C) → (C,A,B) → (B,C,A) → (A,B,C); rot_idx 0,1,2,0.
- ROWS=5: 7 consecutive row_adv → rot_idx 1,2,3,4,0,1,2. Line 0 carries slice (0−r) mod 5 at every step.
- Load set X, load set Y (shadow), check w_ready=0, then w_swap together with row_adv.
  - Required: lines = Y in identity order, rot_idx=0, w_ready=1.
- ACTIVE with set X, w_swap and w_valid with set Z in the same cycle.
  - Required: lines=Z next cycle, out_valid stays 1, state ACTIVE.
- ACTIVE, w_swap with no load → out_valid=0 next cycle.
  - Lines=0 with WROT_ZERO_IDLE_EN defined; lines unchanged without it.
  - A subsequent row_adv leaves rot_idx=0.
- rst asserted while FULL with r=2, concurrent w_swap.
  - Required next cycle: out_valid=0, rot_idx=0, w_ready=1, lines=0.
